// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and helpers for the instruction ROM arbiter.
// Owner encoding records which requester received the last ROM access.
package inst_rom_arbiter_pkg;

  localparam logic ARB_OWNER_CPU = 1'b0;
  localparam logic ARB_OWNER_DBG = 1'b1;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int STARVE_CNT_W = 4;

  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  // Increment that parks at the limit instead of wrapping.
  function automatic starve_cnt_t starve_sat_inc(input starve_cnt_t cnt,
                                                 input starve_cnt_t limit);
    if (cnt >= limit) return limit;
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/inst_rom_arb_starve.sv
// Counts consecutive denied debug-request cycles and raises force_dbg
// once the limit is reached, so debug wins the next contended cycle.
module inst_rom_arb_starve
  import inst_rom_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

  starve_cnt_t starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      starve_cnt <= starve_sat_inc(starve_cnt, LIMIT);
    end else begin
      starve_cnt <= '0;
    end
  end

  assign force_dbg = (starve_cnt >= LIMIT);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational instruction ROM between CPU fetch and the debug
// read port; one access per cycle, response registered with one-cycle latency.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              stallreq,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  logic force_dbg;
  logic resp_valid;
  logic last_owner;

  inst_rom_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .force_dbg(force_dbg)
  );

  // Grants are gated by reset so nothing reaches the ROM while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (dbg_req && (!cpu_req || force_dbg)) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  assign stallreq = cpu_req & ~cpu_gnt;
  assign rom_ce   = (cpu_gnt | dbg_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = cpu_gnt ? cpu_addr : (dbg_gnt ? dbg_addr : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      last_owner <= ARB_OWNER_CPU;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      resp_valid <= (rom_ce == CHIP_ENABLE);
      if (cpu_gnt) begin
        last_owner <= ARB_OWNER_CPU;
        cpu_rdata  <= rom_inst;
      end
      if (dbg_gnt) begin
        last_owner <= ARB_OWNER_DBG;
        dbg_rdata  <= rom_inst;
      end
    end
  end

  // Flush only squashes the CPU response already in flight this cycle.
  assign cpu_rvalid = resp_valid && (last_owner == ARB_OWNER_CPU) && !flush;
  assign dbg_rvalid = resp_valid && (last_owner == ARB_OWNER_DBG);

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_inst_rom_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dbg_req, flush;
  logic [31:0] cpu_addr, dbg_addr;
  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, stallreq, rom_ce;
  logic [31:0] cpu_rdata, dbg_rdata, rom_addr, rom_inst;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_rom_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .flush(flush),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .stallreq(stallreq), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst)
  );

  // ROM model: word-indexed, poisoned value for anything outside the array.
  assign rom_inst = (rom_addr[31:8] == 24'h0 && rom_addr[1:0] == 2'b00)
                    ? mem[rom_addr[7:2]] : 32'hDEADBEEF;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesters must keep the address stable while waiting for a grant.
  a_cpu_hold: assert property (@(posedge clk) disable iff (!rst)
    (cpu_req && !cpu_gnt) |=> (!cpu_req || $stable(cpu_addr)));
  a_dbg_hold: assert property (@(posedge clk) disable iff (!rst)
    (dbg_req && !dbg_gnt) |=> (!dbg_req || $stable(dbg_addr)));

  // Behavioural model: debug wins only when alone or after waiting
  // STARVE_LIMIT consecutive cycles; responses follow grants by one cycle.
  int          waited = 0;
  logic        p_valid = 1'b0, p_dbg = 1'b0;
  logic [31:0] p_word = 32'h0;
  logic        m_cpu_g = 1'b0, m_dbg_g = 1'b0;

  always @(negedge clk) begin
    logic        cw, dw;
    logic [31:0] ea;
    if (!rst) begin
      chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk1("rst_rom_ce", rom_ce, 1'b0);
      chk32("rst_rom_addr", rom_addr, 32'h0);
      chk1("rst_stallreq", stallreq, cpu_req);
      chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
      waited  = 0;
      p_valid = 1'b0;
      m_cpu_g = 1'b0;
      m_dbg_g = 1'b0;
    end else begin
      dw = dbg_req && (!cpu_req || waited >= STARVE_LIMIT);
      cw = cpu_req && !dw;
      ea = cw ? cpu_addr : (dw ? dbg_addr : 32'h0);
      chk1("cpu_gnt", cpu_gnt, cw);
      chk1("dbg_gnt", dbg_gnt, dw);
      chk1("rom_ce", rom_ce, cw || dw);
      chk32("rom_addr", rom_addr, ea);
      chk1("stallreq", stallreq, cpu_req && !cw);
      chk1("cpu_rvalid", cpu_rvalid, p_valid && !p_dbg && !flush);
      if (p_valid && !p_dbg) chk32("cpu_rdata", cpu_rdata, p_word);
      chk1("dbg_rvalid", dbg_rvalid, p_valid && p_dbg);
      if (p_valid && p_dbg) chk32("dbg_rdata", dbg_rdata, p_word);
      waited  = (dbg_req && !dw) ? waited + 1 : 0;
      p_valid = cw || dw;
      p_dbg   = dw;
      p_word  = mem[ea[7:2]];
      m_cpu_g = cw;
      m_dbg_g = dw;
    end
  end

  logic [9:0] pat10;
  logic [4:0] pat5;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h34011100;
    mem[1] = 32'h34020020;
    mem[2] = 32'h3403ff00;

    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0;
    dbg_req = 1'b0; dbg_addr = 32'h0; flush = 1'b0;
    #2;
    chk1("init_cpu_gnt", cpu_gnt, 1'b0);
    chk1("init_stallreq", stallreq, 1'b1);
    chk1("init_cpu_rvalid", cpu_rvalid, 1'b0);
    chk32("init_cpu_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    step(); rst = 1'b1;

    // CPU only, three sequential fetches
    step(); cpu_req = 1'b1; cpu_addr = 32'h0; #2;
    chk1("cpu0_gnt", cpu_gnt, 1'b1); chk1("cpu0_stall", stallreq, 1'b0);
    step(); cpu_addr = 32'h4; #2;
    chk1("cpu1_gnt", cpu_gnt, 1'b1); chk1("cpu1_rvalid", cpu_rvalid, 1'b1);
    chk32("cpu1_rdata", cpu_rdata, 32'h34011100);
    step(); cpu_addr = 32'h8; #2;
    chk32("cpu2_rdata", cpu_rdata, 32'h34020020); chk1("cpu2_stall", stallreq, 1'b0);
    step(); cpu_req = 1'b0; #2;
    chk1("cpu3_rvalid", cpu_rvalid, 1'b1); chk32("cpu3_rdata", cpu_rdata, 32'h3403ff00);

    // Debug only
    step(); dbg_req = 1'b1; dbg_addr = 32'h10; #2;
    chk1("dbg_only_gnt", dbg_gnt, 1'b1); chk1("dbg_only_cpu_gnt", cpu_gnt, 1'b0);
    step(); dbg_req = 1'b0; #2;
    chk1("dbg_only_rvalid", dbg_rvalid, 1'b1);
    chk32("dbg_only_rdata", dbg_rdata, mem[4]);
    chk1("dbg_only_cpu_rvalid", cpu_rvalid, 1'b0);

    // Contention: debug wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(); cpu_req = 1'b1; cpu_addr = 32'h40; dbg_req = 1'b1; dbg_addr = 32'h44; #2;
      pat10[i] = dbg_gnt;
      if (i == 4) chk1("contend_stall", stallreq, 1'b1);
    end
    chk32("contend_pattern", 32'(pat10), 32'h210);
    step(); dbg_req = 1'b0; #2;
    chk1("contend_cpu_back", cpu_gnt, 1'b1);

    // Flush squashes only the in-flight response
    step(); cpu_addr = 32'h20; #2;
    chk1("flush_gnt_n", cpu_gnt, 1'b1);
    step(); cpu_addr = 32'h24; flush = 1'b1; #2;
    chk1("flush_rvalid_n1", cpu_rvalid, 1'b0); chk1("flush_gnt_n1", cpu_gnt, 1'b1);
    step(); cpu_req = 1'b0; flush = 1'b0; #2;
    chk1("flush_rvalid_n2", cpu_rvalid, 1'b1); chk32("flush_rdata_n2", cpu_rdata, mem[9]);

    // Reset in the response cycle
    step(); cpu_req = 1'b1; cpu_addr = 32'h0; #2;
    chk1("rstmid_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 1'b0;
    chk1("rstmid_pre_rvalid", cpu_rvalid, 1'b1);
    #1 rst = 1'b0; #1;
    chk1("rstmid_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rstmid_dbg_rvalid", dbg_rvalid, 1'b0);
    chk32("rstmid_cpu_rdata", cpu_rdata, 32'h0);
    step(); rst = 1'b1;
    step(); cpu_req = 1'b1; cpu_addr = 32'h8; #2;
    chk1("rstpost_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 1'b0; #2;
    chk1("rstpost_rvalid", cpu_rvalid, 1'b1); chk32("rstpost_rdata", cpu_rdata, 32'h3403ff00);

    // Withdrawn debug request restarts the wait
    for (int i = 0; i < 3; i++) begin
      step(); cpu_req = 1'b1; cpu_addr = 32'h40; dbg_req = 1'b1; dbg_addr = 32'h48; #2;
      chk1("withdraw_pre_cpu", cpu_gnt, 1'b1);
    end
    step(); dbg_req = 1'b0; #2;
    chk1("withdraw_gap_cpu", cpu_gnt, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(); dbg_req = 1'b1; #2;
      pat5[i] = dbg_gnt;
    end
    chk32("withdraw_pattern", 32'(pat5), 32'h10);
    step(); dbg_req = 1'b0;

    // Randomized traffic, legal hold protocol
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!(cpu_req && !m_cpu_g)) begin
        cpu_req  = ($urandom_range(0, 9) < 6);
        cpu_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!(dbg_req && !m_dbg_g)) begin
        dbg_req  = ($urandom_range(0, 1) == 1);
        dbg_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      flush = ($urandom_range(0, 3) == 0);
    end
    step(); cpu_req = 1'b0; dbg_req = 1'b0; flush = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
